// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator with strobes, frame counter and delayed sync/bright
// Optional colour-bar test pattern output when VGA_TESTPAT_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int PIPE_DLY = 1,
  parameter int CNT_W    = 10,
  parameter int FRAME_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  output logic [CNT_W-1:0]   h_count,
  output logic [CNT_W-1:0]   v_count,
  output logic               bright,
  output logic               h_sync,
  output logic               v_sync,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count,
  output logic               bright_d,
  output logic               h_sync_d,
  output logic               v_sync_d
`ifdef VGA_TESTPAT_EN
  ,
  output logic [2:0]         rgb_test
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam logic H_ACT_LVL = (H_POL != 0);
  localparam logic V_ACT_LVL = (V_POL != 0);

  if (((64'd1 << CNT_W) < 64'(H_TOTAL)) || ((64'd1 << CNT_W) < 64'(V_TOTAL))) begin : g_cnt_w_chk
    $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 8) begin : g_dly_chk
    $error("vga_timing_gen: PIPE_DLY must be 0..8");
  end

  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             h_wrap, bright_nxt, h_sync_nxt, v_sync_nxt;

  always_comb begin
    h_wrap = (h_count == CNT_W'(H_TOTAL - 1));
    h_nxt  = h_wrap ? '0 : h_count + 1'b1;
    v_nxt  = v_count;
    if (h_wrap) begin
      v_nxt = (v_count == CNT_W'(V_TOTAL - 1)) ? '0 : v_count + 1'b1;
    end
    bright_nxt = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
    h_sync_nxt = ((int'(h_nxt) >= HS_BEG) && (int'(h_nxt) < HS_END)) ? H_ACT_LVL : ~H_ACT_LVL;
    v_sync_nxt = ((int'(v_nxt) >= VS_BEG) && (int'(v_nxt) < VS_END)) ? V_ACT_LVL : ~V_ACT_LVL;
  end

`ifdef VGA_TESTPAT_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int PW    = 6;
  if (BAR_W < 1) begin : g_bar_chk
    $error("vga_timing_gen: H_ACTIVE must be >= 8 for the test pattern");
  end

  logic [CNT_W-1:0] bar_cnt, bar_cnt_nxt;
  logic [3:0]       bar_idx, bar_idx_nxt;
  logic [2:0]       rgb_q, rgb_nxt;

  // Bar index tracks h_nxt so the registered colour lines up with the counts.
  always_comb begin
    bar_cnt_nxt = bar_cnt;
    bar_idx_nxt = bar_idx;
    if (h_nxt == '0) begin
      bar_cnt_nxt = '0;
      bar_idx_nxt = '0;
    end else if (int'(h_nxt) < H_ACTIVE) begin
      if (bar_cnt == CNT_W'(BAR_W - 1)) begin
        bar_cnt_nxt = '0;
        if (bar_idx != 4'd8) bar_idx_nxt = bar_idx + 4'd1;
      end else begin
        bar_cnt_nxt = bar_cnt + 1'b1;
      end
    end
    rgb_nxt = !bright_nxt ? 3'd0 : (bar_idx_nxt[3] ? 3'd7 : bar_idx_nxt[2:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bar_cnt <= '0;
      bar_idx <= '0;
      rgb_q   <= '0;
    end else if (ena) begin
      bar_cnt <= bar_cnt_nxt;
      bar_idx <= bar_idx_nxt;
      rgb_q   <= rgb_nxt;
    end
  end
`else
  localparam int PW = 3;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_count     <= CNT_W'(H_TOTAL - 1);
      v_count     <= CNT_W'(V_TOTAL - 1);
      bright      <= 1'b0;
      h_sync      <= ~H_ACT_LVL;
      v_sync      <= ~V_ACT_LVL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '1;
    end else if (ena) begin
      h_count     <= h_nxt;
      v_count     <= v_nxt;
      bright      <= bright_nxt;
      h_sync      <= h_sync_nxt;
      v_sync      <= v_sync_nxt;
      line_start  <= (h_nxt == '0);
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
      if ((h_nxt == '0) && (v_nxt == '0)) frame_count <= frame_count + 1'b1;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  logic [PW-1:0] cur_vec, d_vec, rst_vec;

`ifdef VGA_TESTPAT_EN
  assign cur_vec  = {bright, h_sync, v_sync, rgb_q};
  assign rst_vec  = {1'b0, ~H_ACT_LVL, ~V_ACT_LVL, 3'd0};
  assign rgb_test = d_vec[2:0];
  assign {bright_d, h_sync_d, v_sync_d} = d_vec[5:3];
`else
  assign cur_vec  = {bright, h_sync, v_sync};
  assign rst_vec  = {1'b0, ~H_ACT_LVL, ~V_ACT_LVL};
  assign {bright_d, h_sync_d, v_sync_d} = d_vec;
`endif

  if (PIPE_DLY == 0) begin : g_no_dly
    assign d_vec = cur_vec;
  end else begin : g_dly
    logic [PW-1:0] pipe [PIPE_DLY];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE_DLY; i++) pipe[i] <= rst_vec;
      end else if (ena) begin
        pipe[0] <= cur_vec;
        for (int i = 1; i < PIPE_DLY; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign d_vec = pipe[PIPE_DLY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized-ena bench for vga_timing_gen against an arithmetic position model
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int k        = 0;  // ena ticks since last reset
  logic tick   = 1'b0;

  // A: default 640x480, PIPE_DLY=2
  logic [9:0] a_h, a_v;
  logic a_b, a_hs, a_vs, a_ls, a_fs, a_bd, a_hsd, a_vsd;
  logic [7:0] a_fc;
  logic [2:0] a_rgb;
  // B: 8/2/2/2 x 4/1/1/1, positive syncs, PIPE_DLY=0
  logic [3:0] b_h, b_v;
  logic b_b, b_hs, b_vs, b_ls, b_fs, b_bd, b_hsd, b_vsd;
  logic [7:0] b_fc;
  logic [2:0] b_rgb;
  // C: same small timing, PIPE_DLY=8, 2-bit frame counter
  logic [3:0] c_h, c_v;
  logic c_b, c_hs, c_vs, c_ls, c_fs, c_bd, c_hsd, c_vsd;
  logic [1:0] c_fc;
  logic [2:0] c_rgb;

`ifndef VGA_TESTPAT_EN
  assign a_rgb = 3'd0;
  assign b_rgb = 3'd0;
  assign c_rgb = 3'd0;
`endif

  vga_timing_gen #(.PIPE_DLY(2)) u_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .h_count(a_h), .v_count(a_v), .bright(a_b),
    .h_sync(a_hs), .v_sync(a_vs), .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc),
    .bright_d(a_bd), .h_sync_d(a_hsd), .v_sync_d(a_vsd)
`ifdef VGA_TESTPAT_EN
    , .rgb_test(a_rgb)
`endif
  );

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1), .PIPE_DLY(0), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .h_count(b_h), .v_count(b_v), .bright(b_b),
    .h_sync(b_hs), .v_sync(b_vs), .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc),
    .bright_d(b_bd), .h_sync_d(b_hsd), .v_sync_d(b_vsd)
`ifdef VGA_TESTPAT_EN
    , .rgb_test(b_rgb)
`endif
  );

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .H_POL(1), .V_POL(1), .PIPE_DLY(8), .CNT_W(4),
                   .FRAME_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .ena(ena), .h_count(c_h), .v_count(c_v), .bright(c_b),
    .h_sync(c_hs), .v_sync(c_vs), .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc),
    .bright_d(c_bd), .h_sync_d(c_hsd), .v_sync_d(c_vsd)
`ifdef VGA_TESTPAT_EN
    , .rgb_test(c_rgb)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (tick %0d, t=%0t)", tag, got, exp, k, $time);
  endtask

  typedef struct {
    int h;
    int v;
    int b;
    int hs;
    int vs;
    int rgb;
  } pos_t;

  typedef struct {
    int ha; int hf; int hsw; int hb;
    int va; int vf; int vsw; int vb;
    int hp; int vp; int dly; int fw;
  } cfg_t;

  // Raster position after t ticks: tick 1 lands on (0,0), tick 0 sits one pixel before it.
  function automatic pos_t model_at(input cfg_t c, input int t);
    pos_t p;
    int ht, vt, q;
    ht  = c.ha + c.hf + c.hsw + c.hb;
    vt  = c.va + c.vf + c.vsw + c.vb;
    q   = t + ht * vt - 1;
    p.h = q % ht;
    p.v = (q / ht) % vt;
    p.b = (p.h < c.ha && p.v < c.va) ? 1 : 0;
    p.hs = (p.h >= c.ha + c.hf && p.h < c.ha + c.hf + c.hsw) ? c.hp : 1 - c.hp;
    p.vs = (p.v >= c.va + c.vf && p.v < c.va + c.vf + c.vsw) ? c.vp : 1 - c.vp;
    if (p.b == 0) p.rgb = 0;
    else if (p.h / (c.ha / 8) > 7) p.rgb = 7;
    else p.rgb = p.h / (c.ha / 8);
    return p;
  endfunction

  task automatic verify(input string nm, input cfg_t c, input int oh, input int ov, input int ob,
                        input int ohs, input int ovs, input int ols, input int ofs, input int ofc,
                        input int obd, input int ohsd, input int ovsd, input int orgb);
    pos_t p, pd;
    int ftot, mask, fc;
    ftot = (c.ha + c.hf + c.hsw + c.hb) * (c.va + c.vf + c.vsw + c.vb);
    mask = (1 << c.fw) - 1;
    p    = model_at(c, k);
    pd   = model_at(c, (k >= c.dly) ? k - c.dly : 0);
    fc   = (k == 0) ? mask : ((k - 1) / ftot) & mask;
    check({nm, ".h_count"}, oh, p.h);
    check({nm, ".v_count"}, ov, p.v);
    check({nm, ".bright"}, ob, p.b);
    check({nm, ".h_sync"}, ohs, p.hs);
    check({nm, ".v_sync"}, ovs, p.vs);
    check({nm, ".line_start"}, ols, (tick && p.h == 0) ? 1 : 0);
    check({nm, ".frame_start"}, ofs, (tick && p.h == 0 && p.v == 0) ? 1 : 0);
    check({nm, ".frame_count"}, ofc, fc);
    check({nm, ".bright_d"}, obd, pd.b);
    check({nm, ".h_sync_d"}, ohsd, pd.hs);
    check({nm, ".v_sync_d"}, ovsd, pd.vs);
`ifdef VGA_TESTPAT_EN
    check({nm, ".rgb_test"}, orgb, pd.rgb);
`else
    if (orgb != 0) check({nm, ".rgb_tie"}, orgb, 0);
`endif
  endtask

  cfg_t cfg_a, cfg_b, cfg_c;

  task automatic step(input logic en, input logic rn);
    ena   = en;
    rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      k    = 0;
      tick = 1'b0;
    end else begin
      tick = en;
      if (en) k++;
    end
    @(negedge clk);
    verify("A", cfg_a, int'(a_h), int'(a_v), int'(a_b), int'(a_hs), int'(a_vs), int'(a_ls),
           int'(a_fs), int'(a_fc), int'(a_bd), int'(a_hsd), int'(a_vsd), int'(a_rgb));
    verify("B", cfg_b, int'(b_h), int'(b_v), int'(b_b), int'(b_hs), int'(b_vs), int'(b_ls),
           int'(b_fs), int'(b_fc), int'(b_bd), int'(b_hsd), int'(b_vsd), int'(b_rgb));
    verify("C", cfg_c, int'(c_h), int'(c_v), int'(c_b), int'(c_hs), int'(c_vs), int'(c_ls),
           int'(c_fs), int'(c_fc), int'(c_bd), int'(c_hsd), int'(c_vsd), int'(c_rgb));
  endtask

  initial begin
    cfg_a = '{ha:640, hf:16, hsw:96, hb:48, va:480, vf:10, vsw:2, vb:33, hp:0, vp:0, dly:2, fw:8};
    cfg_b = '{ha:8, hf:2, hsw:2, hb:2, va:4, vf:1, vsw:1, vb:1, hp:1, vp:1, dly:0, fw:8};
    cfg_c = '{ha:8, hf:2, hsw:2, hb:2, va:4, vf:1, vsw:1, vb:1, hp:1, vp:1, dly:8, fw:2};
    rst_n = 1'b0;
    ena   = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 1700; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 1700; i++) step((i % 2) == 0, 1'b1);
    for (int i = 0; i < 12000; i++) step($urandom_range(0, 3) != 0, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 1) != 0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 2500; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 500; i++) step($urandom_range(0, 4) == 0, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
